luks_sample_logger: RTL

LUKS_SAMPLE_LOGGER -- requirements
Module: luks_sample_logger

---
 rtl/luks_pkg.sv | 18 +
 rtl/luks_fifo.sv | 59 +++++
 rtl/luks_sample_logger.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/luks_pkg.sv
// Shared definitions for the sample logger: FSM state encoding, sample width
// and the default parameter values used by the top level and the FIFO.
package luks_pkg;

    localparam int SAMPLE_W    = 8;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_AVG_LEN = 8;
    localparam int DEF_TIMEOUT = 4096;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TICK = 3'd1,
        ST_REQUEST   = 3'd2,
        ST_CAPTURE   = 3'd3,
        ST_RELEASE   = 3'd4
    } state_t;

endpackage

// File: rtl/luks_fifo.sv
// Circular-buffer sample FIFO with first-word-fall-through read data.
// A push into a full FIFO is dropped and latches the sticky overflow flag,
// unless a pop happens in the same cycle, in which case both are performed.
module luks_fifo
    import luks_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = SAMPLE_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    pop,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              pop_ok;
    logic              push_ok;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign push_ok = push && (!full || pop_ok);
    // Head is shown directly; forced to zero while empty so reset reads as 0.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Pointer, occupancy and overflow bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (!push_ok && pop_ok) count <= count - 1'b1;
            if (push && !push_ok) overflow <= 1'b1;
        end
    end

    // Storage array; holds data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/luks_sample_logger.sv
// Periodic SPI sample logger: paces conversion requests to an SPI master,
// stores returned samples in a FIFO and keeps a moving average over the
// most recent AVG_LEN samples. spi_ready arrives asynchronously and is only
// used after a two-flop synchronizer.
module luks_sample_logger
    import luks_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int AVG_LEN = DEF_AVG_LEN,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [15:0]             period,
    output logic                    spi_valid,
    input  logic                    spi_ready,
    input  logic [7:0]              spi_data,
    input  logic                    rd_en,
    output logic [7:0]              rd_data,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    timeout_err,
    output logic [7:0]              avg,
    output logic                    avg_valid
);

    localparam int AVG_SH = $clog2(AVG_LEN);
    localparam int SUM_W  = SAMPLE_W + AVG_SH;
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    state_t              state;
    logic                ready_meta;
    logic                ready_sync;
    logic                ready_seen_low;
    logic [15:0]         tick_cnt;
    logic [15:0]         reload;
    logic [TO_W-1:0]     to_cnt;
    logic                capture;
    logic [SUM_W-1:0]    sum;
    logic [SAMPLE_W-1:0] hist [AVG_LEN];
    logic [AVG_SH-1:0]   hist_idx;
    logic [AVG_SH:0]     fill_cnt;

    // A period of 0 behaves like 1: request every WAIT_TICK pass with no extra wait.
    assign reload    = (period == 16'd0) ? 16'd0 : period - 16'd1;
    assign capture   = (state == ST_CAPTURE);
    assign spi_valid = (state == ST_REQUEST) || capture;

    // Two-flop synchronizer. Resets to "ready high" so that a request is never
    // issued until a genuine low level has been observed after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_meta <= 1'b1;
            ready_sync <= 1'b1;
        end else begin
            ready_meta <= spi_ready;
            ready_sync <= ready_meta;
        end
    end

    // Conversion sequencer: interval pacing, request/timeout, release handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            tick_cnt       <= 16'd0;
            to_cnt         <= '0;
            timeout_err    <= 1'b0;
            ready_seen_low <= 1'b0;
        end else begin
            if (!ready_sync) ready_seen_low <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state    <= ST_WAIT_TICK;
                        tick_cnt <= reload;
                    end
                end
                ST_WAIT_TICK: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (tick_cnt != 16'd0) begin
                        tick_cnt <= tick_cnt - 16'd1;
                    end else if (ready_seen_low) begin
                        state  <= ST_REQUEST;
                        to_cnt <= '0;
                    end
                end
                ST_REQUEST: begin
                    if (ready_sync) begin
                        state <= ST_CAPTURE;
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        state       <= ST_RELEASE;
                        timeout_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!ready_sync) begin
                        if (enable) begin
                            state    <= ST_WAIT_TICK;
                            tick_cnt <= reload;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Moving average: replace the oldest history entry and adjust the running
    // sum; every captured sample counts, including ones the FIFO dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum      <= '0;
            hist_idx <= '0;
            fill_cnt <= '0;
            for (int i = 0; i < AVG_LEN; i++) hist[i] <= '0;
        end else if (capture) begin
            sum           <= sum + SUM_W'(spi_data) - SUM_W'(hist[hist_idx]);
            hist[hist_idx] <= spi_data;
            hist_idx      <= hist_idx + 1'b1;
            if (fill_cnt != (AVG_SH+1)'(AVG_LEN)) fill_cnt <= fill_cnt + 1'b1;
        end
    end

    assign avg       = sum[SUM_W-1:AVG_SH];
    assign avg_valid = (fill_cnt == (AVG_SH+1)'(AVG_LEN));

    luks_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (SAMPLE_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (capture),
        .wr_data  (spi_data),
        .pop      (rd_en),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

endmodule
